sat_fault_fsm_p: RTL and testbench
==================================

# sat_fault_fsm_p

Parametrised fault-management state machine for the satellite fault-tolerance path. It replaces the fixed three-input N1/N2/C1/C2 mode FSM. It debounces N_FLT raw fault flags and latches confirmed faults. From the latched set it classifies severity and sequences the craft mode through NOM1/NOM2/CRIT1/CRIT2, with a minimum critical dwell and ground-acknowledged recovery. It sits between the sensor fault-flag aggregation and the mode-dependent actuator/redundancy switching logic.

## Interface
- N_FLT, 3: number of fault channels (≥2).
- DEB_CYC, 4: consecutive high samples needed to confirm a fault (≥1).
- HOLD_CYC, 16: minimum cycles spent in a critical mode before de-escalation (≥1).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- flt_in  in  N_FLT  raw fault flags, one per channel, already synchronised.
- crit_mask  in  N_FLT  per-channel critical class; a confirmed fault on a masked channel forces at least CRIT1.
- ack  in  1  ground recovery acknowledge, single-cycle pulse.
- mode  out  2  current mode: NOM1=00, NOM2=01, CRIT1=10, CRIT2=11.
- N1, N2, C1, C2  out  1 each  one-hot decode of mode.
- flt_lat  out  N_FLT  latched confirmed faults.
- flt_cnt  out  $clog2(N_FLT+1)  popcount of flt_lat.
- hold_busy  out  1  high while the critical dwell timer is nonzero.

## Operation
- Debounce per channel: a counter saturates at DEB_CYC. It increments on each edge that samples flt_in[i]=1 and clears to 0 on any edge that samples 0.
- Confirm: flt_lat[i] sets on the edge where the counter reaches DEB_CYC, i.e. on the DEB_CYC-th consecutive high sample. Once set, it stays set after flt_in[i] falls.
- Clear: ack clears flt_lat[i] only if all three hold:
  - hold_busy=0;
  - channel counter = 0;
  - the channel is not confirming on the same edge.
  When ack and a confirm coincide on a channel, the set wins. ack while hold_busy=1 is ignored entirely and is not remembered.
- Target severity is computed from the registered flt_lat:
  - CRIT2 if flt_cnt==N_FLT;
  - else CRIT1 if flt_cnt≥2 or (flt_lat & crit_mask)≠0;
  - else NOM2 if flt_cnt==1;
  - else NOM1.
- Escalation (target > mode): mode takes the target on the next edge, unconditionally.
- Entering CRIT1 or CRIT2 from a lower mode, or CRIT1→CRIT2, loads hold_cnt=HOLD_CYC. hold_cnt then decrements by 1 per edge down to 0. Re-entering the same mode does not reload it.
- De-escalation (target < mode):
  - from NOM2, immediate;
  - from CRIT1/CRIT2, only on an edge where hold_cnt==0; the mode then jumps directly to the target, possibly skipping levels.
- Any rst edge, including one mid-dwell or mid-debounce, resets all state:
  - debounce counters = 0, flt_lat = 0, flt_cnt = 0;
  - hold_cnt = 0, hold_busy = 0;
  - mode = NOM1, so N1=1 and N2=C1=C2=0.
- crit_mask is sampled combinationally into the target each cycle and is not latched.

## Timing
- A fault held high from edge k is reflected in flt_lat after edge k+DEB_CYC-1. mode reflects it one edge later, giving total latency DEB_CYC edges from the first high sample to the mode change.
- N1/N2/C1/C2, flt_cnt and hold_busy are decodes of registers with no extra latency beyond the register.
- A one-cycle glitch shorter than DEB_CYC samples never changes any output.
- After an ack clear, mode follows one edge later, subject to the hold rule.

## Structure
- Package sat_fsm_pkg holds:
  - the mode_t enum (NOM1, NOM2, CRIT1, CRIT2) with the encodings above;
  - the severity ordering;
  - the width helper for the counter.
- Sub-module sat_debounce (parameter DEB_CYC): per-channel saturating counter with a confirm pulse and a zero flag, instantiated N_FLT times with a generate loop.
- The top level holds flt_lat, the popcount, the target logic, the mode register and hold_cnt.

## Test plan
Common setup: N_FLT=3, DEB_CYC=4, HOLD_CYC=16.
- Reset/glitch: rst for 2 cycles, then flt_in=001 for 3 cycles then 000. Required: mode=00 and N1=1 throughout; flt_lat stays 000.
- Single fault: flt_in=001 held. Required: flt_lat=001 after the 4th edge and mode=01 (N2=1) after the 5th. Then drop flt_in and pulse ack. Required: flt_lat=000, then mode=00 the next edge.
- Critical mask: crit_mask=010, flt_in=010 held. Required: mode=10 (C1=1), hold_busy=1. Drop the input and pulse ack at cycle 5 of the dwell: ignored, flt_lat stays 010. Pulse ack after hold_busy falls: flt_lat=000, mode=00.
- Full escalation: flt_in=011, then 111 two cycles later. Required: mode 10, then 11, with hold_cnt reloaded to 16 at the CRIT2 entry.
- Mid-dwell reset: in CRIT2 with hold_cnt=8, assert rst for one edge. Required: every output is at its reset value on the next cycle.
- Ack/confirm collision: channel 0 debounce count=3 with flt_lat[0] already set from a prior event (counter cleared, then re-rising), and ack arriving on the confirm edge. Required: flt_lat[0] remains 1.

Source files
------------

// File: rtl/sat_fsm_pkg.sv
// Shared types and helpers for the satellite fault-management FSM.
package sat_fsm_pkg;

    typedef enum logic [1:0] {
        NOM1  = 2'b00,
        NOM2  = 2'b01,
        CRIT1 = 2'b10,
        CRIT2 = 2'b11
    } mode_t;

    // Severity rank; the mode encoding is already ordered least to most severe.
    function automatic logic [1:0] sev(input mode_t m);
        return 2'(m);
    endfunction

    // Bits needed for a counter spanning 0..n inclusive.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sat_debounce.sv
// Per-channel saturating debounce counter with confirm pulse and zero flag.
module sat_debounce
    import sat_fsm_pkg::*;
#(
    parameter int unsigned DEB_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic flt,
    output logic confirm_c,
    output logic zero_c
);

    localparam int unsigned CW = cnt_w(DEB_CYC);

    logic [CW-1:0] cnt;

    assign zero_c    = (cnt == '0);
    // Fires only on the edge that takes the count up to DEB_CYC, not while saturated.
    assign confirm_c = flt && (cnt == CW'(DEB_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!flt) begin
            cnt <= '0;
        end else if (cnt != CW'(DEB_CYC)) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sat_fault_fsm_p.sv
// Fault latching, severity classification and NOM/CRIT mode sequencing with
// minimum critical dwell and ground-acknowledged recovery.
module sat_fault_fsm_p
    import sat_fsm_pkg::*;
#(
    parameter int unsigned N_FLT    = 3,
    parameter int unsigned DEB_CYC  = 4,
    parameter int unsigned HOLD_CYC = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_FLT-1:0]             flt_in,
    input  logic [N_FLT-1:0]             crit_mask,
    input  logic                         ack,
    output logic [1:0]                   mode,
    output logic                         N1,
    output logic                         N2,
    output logic                         C1,
    output logic                         C2,
    output logic [N_FLT-1:0]             flt_lat,
    output logic [$clog2(N_FLT+1)-1:0]   flt_cnt,
    output logic                         hold_busy
);

    localparam int unsigned FW = cnt_w(N_FLT);
    localparam int unsigned HW = cnt_w(HOLD_CYC);

    logic [N_FLT-1:0] confirm;
    logic [N_FLT-1:0] zero;
    logic [N_FLT-1:0] clr;
    logic [N_FLT-1:0] lat_nxt;
    logic [FW-1:0]    cnt_nxt;
    logic [HW-1:0]    hold_cnt;
    logic [HW-1:0]    hold_nxt;
    mode_t            mode_r;
    mode_t            mode_nxt;
    mode_t            target;

    for (genvar i = 0; i < N_FLT; i++) begin : g_deb
        sat_debounce #(
            .DEB_CYC (DEB_CYC)
        ) u_deb (
            .clk       (clk),
            .rst       (rst),
            .flt       (flt_in[i]),
            .confirm_c (confirm[i]),
            .zero_c    (zero[i])
        );
    end

    // Ack clears only idle, non-confirming channels and only outside the dwell.
    assign clr  = {N_FLT{ack & ~hold_busy}} & zero & ~confirm;
    assign mode = mode_r;

    always_comb begin
        lat_nxt = (flt_lat | confirm) & ~clr;

        cnt_nxt = '0;
        for (int i = 0; i < int'(N_FLT); i++) begin
            cnt_nxt = cnt_nxt + FW'(lat_nxt[i]);
        end

        if (flt_cnt == FW'(N_FLT)) begin
            target = CRIT2;
        end else if (flt_cnt >= FW'(2) || |(flt_lat & crit_mask)) begin
            target = CRIT1;
        end else if (flt_cnt == FW'(1)) begin
            target = NOM2;
        end else begin
            target = NOM1;
        end

        mode_nxt = mode_r;
        hold_nxt = (hold_cnt == '0) ? '0 : hold_cnt - HW'(1);

        // Escalate immediately; every climb into a critical mode restarts the dwell.
        if (sev(target) > sev(mode_r)) begin
            mode_nxt = target;
            if (sev(target) >= sev(CRIT1)) begin
                hold_nxt = HW'(HOLD_CYC);
            end
        end else if (sev(target) < sev(mode_r)) begin
            if (mode_r == NOM2 || hold_cnt == '0) begin
                mode_nxt = target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flt_lat   <= '0;
            flt_cnt   <= '0;
            hold_cnt  <= '0;
            hold_busy <= 1'b0;
            mode_r    <= NOM1;
            N1        <= 1'b1;
            N2        <= 1'b0;
            C1        <= 1'b0;
            C2        <= 1'b0;
        end else begin
            flt_lat   <= lat_nxt;
            flt_cnt   <= cnt_nxt;
            hold_cnt  <= hold_nxt;
            hold_busy <= (hold_nxt != '0);
            mode_r    <= mode_nxt;
            N1        <= (mode_nxt == NOM1);
            N2        <= (mode_nxt == NOM2);
            C1        <= (mode_nxt == CRIT1);
            C2        <= (mode_nxt == CRIT2);
        end
    end

endmodule

// File: tb/tb_sat_fault_fsm_p.sv
// Self-checking bench for sat_fault_fsm_p: directed scenarios plus randomized traffic
// against a behavioural reference model.
module tb_sat_fault_fsm_p;

    localparam int N    = 3;
    localparam int DEB  = 4;
    localparam int HOLD = 16;

    logic         clk;
    logic         rst;
    logic [N-1:0] flt_in;
    logic [N-1:0] crit_mask;
    logic         ack;
    logic [1:0]   mode;
    logic         N1, N2, C1, C2;
    logic [N-1:0] flt_lat;
    logic [1:0]   flt_cnt;
    logic         hold_busy;

    int total = 0;
    int bad   = 0;

    sat_fault_fsm_p #(
        .N_FLT    (N),
        .DEB_CYC  (DEB),
        .HOLD_CYC (HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flt_in    (flt_in),
        .crit_mask (crit_mask),
        .ack       (ack),
        .mode      (mode),
        .N1        (N1),
        .N2        (N2),
        .C1        (C1),
        .C2        (C2),
        .flt_lat   (flt_lat),
        .flt_cnt   (flt_cnt),
        .hold_busy (hold_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: run lengths of high samples, latched set, mode rank, dwell left.
    int           run [N];
    bit [N-1:0]   m_lat  = '0;
    int           m_mode = 0;
    int           m_hold = 0;

    always @(posedge clk) begin : mdl
        bit [N-1:0] conf;
        bit [N-1:0] was_zero;
        int         tgt;
        int         nc;
        if (rst) begin
            for (int i = 0; i < N; i++) run[i] = 0;
            m_lat  = '0;
            m_mode = 0;
            m_hold = 0;
        end else begin
            nc = $countones(m_lat);
            if (nc == N)                               tgt = 3;
            else if (nc >= 2 || (m_lat & crit_mask) != 0) tgt = 2;
            else if (nc == 1)                          tgt = 1;
            else                                       tgt = 0;
            for (int i = 0; i < N; i++) begin
                was_zero[i] = (run[i] == 0);
                conf[i]     = flt_in[i] && (run[i] == DEB - 1);
                run[i]      = flt_in[i] ? ((run[i] < DEB) ? run[i] + 1 : DEB) : 0;
            end
            for (int i = 0; i < N; i++) begin
                if (conf[i])                                    m_lat[i] = 1'b1;
                else if (ack && m_hold == 0 && was_zero[i])     m_lat[i] = 1'b0;
            end
            if (tgt > m_mode) begin
                m_mode = tgt;
                if (tgt >= 2)        m_hold = HOLD;
                else if (m_hold > 0) m_hold = m_hold - 1;
            end else begin
                if (tgt < m_mode && (m_mode == 1 || m_hold == 0)) m_mode = tgt;
                if (m_hold > 0) m_hold = m_hold - 1;
            end
        end
    end

    always @(posedge clk) begin
        #3;
        chk("mode", 32'(mode), 32'(m_mode));
        chk("onehot", 32'({N1, N2, C1, C2}), 32'(4'b1000 >> m_mode));
        chk("flt_lat", 32'(flt_lat), 32'(m_lat));
        chk("flt_cnt", 32'(flt_cnt), 32'($countones(m_lat)));
        chk("hold_busy", 32'(hold_busy), 32'(m_hold != 0));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; flt_in = '0; crit_mask = '0; ack = 1'b0;
        tick(); tick();
        chk("rst_mode", 32'(mode), 0);
        chk("rst_n1", 32'(N1), 1);
        chk("rst_lat", 32'(flt_lat), 0);

        // Glitch shorter than the debounce window
        rst = 1'b0; flt_in = 3'b001;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("glitch_mode", 32'(mode), 0);
            chk("glitch_lat", 32'(flt_lat), 0);
        end
        flt_in = '0;
        repeat (2) begin
            tick();
            chk("glitch_n1", 32'(N1), 1);
        end

        // Single non-critical fault then ack recovery
        flt_in = 3'b001;
        repeat (3) tick();
        chk("single_lat3", 32'(flt_lat), 0);
        tick();
        chk("single_lat4", 32'(flt_lat), 32'h1);
        chk("single_mode4", 32'(mode), 0);
        tick();
        chk("single_mode5", 32'(mode), 1);
        chk("single_n2", 32'(N2), 1);
        flt_in = '0; tick();
        ack = 1'b1; tick(); ack = 1'b0;
        chk("ack_lat", 32'(flt_lat), 0);
        chk("ack_mode_same", 32'(mode), 1);
        tick();
        chk("ack_mode_next", 32'(mode), 0);

        // Critical-masked channel, ack during dwell ignored
        crit_mask = 3'b010; flt_in = 3'b010;
        repeat (5) tick();
        chk("crit_mode", 32'(mode), 2);
        chk("crit_c1", 32'(C1), 1);
        chk("crit_busy", 32'(hold_busy), 1);
        flt_in = '0;
        repeat (4) tick();
        ack = 1'b1; tick(); ack = 1'b0;
        chk("crit_ack_ign", 32'(flt_lat), 32'h2);
        chk("crit_mode_kept", 32'(mode), 2);
        k = 5;
        while (hold_busy && k < 40) begin tick(); k++; end
        chk("crit_dwell", 32'(k), 16);
        tick();
        chk("crit_mode_post", 32'(mode), 2);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("crit_clr_lat", 32'(flt_lat), 0);
        chk("crit_clr_mode", 32'(mode), 2);
        tick();
        chk("crit_recover", 32'(mode), 0);
        crit_mask = '0;

        // Full escalation CRIT1 -> CRIT2 with dwell reload
        flt_in = 3'b011; repeat (2) tick();
        flt_in = 3'b111; repeat (3) tick();
        chk("esc_mode5", 32'(mode), 2);
        tick();
        chk("esc_lat6", 32'(flt_lat), 32'h7);
        chk("esc_mode6", 32'(mode), 2);
        tick();
        chk("esc_mode7", 32'(mode), 3);
        chk("esc_c2", 32'(C2), 1);
        chk("esc_cnt", 32'(flt_cnt), 3);
        k = 0;
        while (hold_busy && k < 40) begin tick(); k++; end
        chk("esc_dwell", 32'(k), 16);

        // Reset in the middle of a CRIT2 dwell
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (5) tick();
        chk("mid_crit2", 32'(mode), 3);
        repeat (8) tick();
        chk("mid_busy", 32'(hold_busy), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_mode", 32'(mode), 0);
        chk("mid_rst_dec", 32'({N1, N2, C1, C2}), 32'h8);
        chk("mid_rst_lat", 32'(flt_lat), 0);
        chk("mid_rst_cnt", 32'(flt_cnt), 0);
        chk("mid_rst_busy", 32'(hold_busy), 0);
        flt_in = '0; tick();

        // Ack coinciding with a re-confirm on an already latched channel
        flt_in = 3'b001; repeat (4) tick();
        chk("coll_pre", 32'(flt_lat), 32'h1);
        flt_in = '0; tick();
        flt_in = 3'b001; repeat (3) tick();
        ack = 1'b1; tick(); ack = 1'b0;
        chk("coll_lat0", 32'(flt_lat[0]), 1);
        flt_in = '0; tick();
        ack = 1'b1; tick(); ack = 1'b0;
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0) flt_in[i] = ~flt_in[i];
            end
            if ($urandom_range(0, 49) == 0) crit_mask = N'($urandom);
            ack = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; ack = 1'b0; flt_in = '0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
